irda_rxfifo_arbiter: RTL

//  Shares the single receive FIFO write port between the MIR and FIR receivers. Each receiver

---
 rtl/irda_rxfifo_arbiter_pkg.sv | 38 +++
 rtl/irda_rxfifo_arbiter_if.sv | 38 +++
 rtl/irda_rx_hold_buf.sv | 60 ++++++
 rtl/irda_rxfifo_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/irda_rxfifo_arbiter_pkg.sv
// Shared constants, types and helpers for the IrDA RX FIFO write-port arbiter.
package irda_rxfifo_arbiter_pkg;

    localparam int IRDA_FIFO_WIDTH     = 32;
    localparam int IRDA_FIFO_POINTER_W = 4;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_MIR  = 2'b01;
    localparam logic [1:0] OWN_FIR  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GNT_MIR = 2'b01,
        ST_GNT_FIR = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic                       eof;
        logic [IRDA_FIFO_WIDTH-1:0] dat;
    } hold_entry_t;

    function automatic logic [1:0] owner_of(input arb_state_t state);
        logic [1:0] own;
        case (state)
            ST_GNT_MIR: own = OWN_MIR;
            ST_GNT_FIR: own = OWN_FIR;
            default:    own = OWN_NONE;
        endcase
        return own;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/irda_rxfifo_arbiter_if.sv
// Receiver-side and RX-FIFO-side signals of the arbiter; slave = arbiter, master = environment.
interface irda_rxfifo_arbiter_if;

    localparam int W  = irda_rxfifo_arbiter_pkg::IRDA_FIFO_WIDTH;
    localparam int PW = irda_rxfifo_arbiter_pkg::IRDA_FIFO_POINTER_W;

    logic          clear_i;
    logic          fir_mode;
    logic [W-1:0]  mir_dat_i;
    logic          mir_add_i;
    logic          mir_eof_i;
    logic [W-1:0]  fir_dat_i;
    logic          fir_add_i;
    logic          fir_eof_i;
    logic [PW:0]   rxfifo_count_i;
    logic          rxfifo_add_o;
    logic [W-1:0]  rxfifo_dat_o;
    logic [1:0]    owner_o;
    logic          drop_o;
    logic [7:0]    drop_cnt_o;

    modport slave (
        input  clear_i, fir_mode,
        input  mir_dat_i, mir_add_i, mir_eof_i,
        input  fir_dat_i, fir_add_i, fir_eof_i,
        input  rxfifo_count_i,
        output rxfifo_add_o, rxfifo_dat_o, owner_o, drop_o, drop_cnt_o
    );

    modport master (
        output clear_i, fir_mode,
        output mir_dat_i, mir_add_i, mir_eof_i,
        output fir_dat_i, fir_add_i, fir_eof_i,
        output rxfifo_count_i,
        input  rxfifo_add_o, rxfifo_dat_o, owner_o, drop_o, drop_cnt_o
    );

endinterface

// File: rtl/irda_rx_hold_buf.sv
// Two-entry {eof,data} holding buffer; a push on a full buffer is only accepted alongside a pop.
module irda_rx_hold_buf
    import irda_rxfifo_arbiter_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic        i_pop,
    input  hold_entry_t i_ent,
    output hold_entry_t o_head,
    output logic        o_empty,
    output logic        o_full
);

    hold_entry_t r_ent [2];
    logic        r_rd;
    logic        r_wr;
    logic [1:0]  r_cnt;
    logic        w_pop;
    logic        w_push;

    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ent[0] <= '0;
            r_ent[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= 2'd0;
        end else if (i_clr) begin
            r_ent[0] <= '0;
            r_ent[1] <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_ent[r_wr] <= i_ent;
                r_wr        <= ~r_wr;
            end
            if (w_pop) begin
                r_rd <= ~r_rd;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_head  = r_ent[r_rd];
    assign o_empty = (r_cnt == 2'd0);
    assign o_full  = (r_cnt == 2'd2);

endmodule

// File: rtl/irda_rxfifo_arbiter.sv
// Frame-locked arbiter draining the MIR and FIR holding buffers into the shared RX FIFO write port.
module irda_rxfifo_arbiter
    import irda_rxfifo_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    irda_rxfifo_arbiter_if.slave  bus
);

    localparam int               PW        = IRDA_FIFO_POINTER_W;
    localparam logic [PW:0]      DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [7:0]       TO_LAST_C = 8'(TIMEOUT - 1);

    hold_entry_t                 w_mir_in, w_fir_in, w_mir_head, w_fir_head, w_own_head;
    logic                        w_mir_empty, w_fir_empty, w_mir_full, w_fir_full;
    logic                        w_mir_drop, w_fir_drop;
    logic                        w_pop_mir, w_pop_fir, w_push;
    logic                        w_own_ne, w_own_strobe, w_room;
    logic [PW:0]                 w_level;
    arb_state_t                  r_state, w_state_nxt;
    logic [7:0]                  r_to, w_to_nxt;
    logic                        r_add;
    logic [IRDA_FIFO_WIDTH-1:0]  r_dat;
    logic [1:0]                  r_owner;
    logic                        r_drop;
    logic [7:0]                  r_drop_cnt;

    assign w_mir_in = '{eof: bus.mir_eof_i, dat: bus.mir_dat_i};
    assign w_fir_in = '{eof: bus.fir_eof_i, dat: bus.fir_dat_i};

    irda_rx_hold_buf u_mir_buf (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_i),
        .i_clr   (bus.clear_i),
        .i_push  (bus.mir_add_i),
        .i_pop   (w_pop_mir),
        .i_ent   (w_mir_in),
        .o_head  (w_mir_head),
        .o_empty (w_mir_empty),
        .o_full  (w_mir_full)
    );

    irda_rx_hold_buf u_fir_buf (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_i),
        .i_clr   (bus.clear_i),
        .i_push  (bus.fir_add_i),
        .i_pop   (w_pop_fir),
        .i_ent   (w_fir_in),
        .o_head  (w_fir_head),
        .o_empty (w_fir_empty),
        .o_full  (w_fir_full)
    );

    // The level includes the push still registered on rxfifo_add_o, which the FIFO has not counted yet.
    assign w_level    = bus.rxfifo_count_i + {{PW{1'b0}}, r_add};
    assign w_room     = (w_level < DEPTH_C);
    assign w_mir_drop = bus.mir_add_i && w_mir_full && !w_pop_mir;
    assign w_fir_drop = bus.fir_add_i && w_fir_full && !w_pop_fir;

    // View of the buffer that currently owns the FIFO port.
    always_comb begin
        w_own_head   = '0;
        w_own_ne     = 1'b0;
        w_own_strobe = 1'b0;
        case (r_state)
            ST_GNT_MIR: begin
                w_own_head   = w_mir_head;
                w_own_ne     = !w_mir_empty;
                w_own_strobe = bus.mir_add_i;
            end
            ST_GNT_FIR: begin
                w_own_head   = w_fir_head;
                w_own_ne     = !w_fir_empty;
                w_own_strobe = bus.fir_add_i;
            end
            default: begin
                w_own_head   = '0;
                w_own_ne     = 1'b0;
                w_own_strobe = 1'b0;
            end
        endcase
    end

    // Grant selection, push decision and idle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_to_nxt    = r_to;
        w_push      = 1'b0;
        w_pop_mir   = 1'b0;
        w_pop_fir   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_to_nxt = 8'd0;
                if (!w_mir_empty && !w_fir_empty) begin
                    w_state_nxt = bus.fir_mode ? ST_GNT_FIR : ST_GNT_MIR;
                end else if (!w_mir_empty) begin
                    w_state_nxt = ST_GNT_MIR;
                end else if (!w_fir_empty) begin
                    w_state_nxt = ST_GNT_FIR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GNT_MIR, ST_GNT_FIR: begin
                w_push    = w_own_ne && w_room;
                w_pop_mir = w_push && (r_state == ST_GNT_MIR);
                w_pop_fir = w_push && (r_state == ST_GNT_FIR);
                if (w_own_ne || w_own_strobe) begin
                    w_to_nxt = 8'd0;
                end else if (r_to == TO_LAST_C) begin
                    w_to_nxt    = 8'd0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_to_nxt = r_to + 8'd1;
                end
                if (w_push && w_own_head.eof) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = w_state_nxt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_to_nxt    = 8'd0;
            end
        endcase
    end

    // Arbiter state, registered FIFO port and drop accounting.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_to       <= 8'd0;
            r_add      <= 1'b0;
            r_dat      <= '0;
            r_owner    <= OWN_NONE;
            r_drop     <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (bus.clear_i) begin
            r_state    <= ST_IDLE;
            r_to       <= 8'd0;
            r_add      <= 1'b0;
            r_dat      <= '0;
            r_owner    <= OWN_NONE;
            r_drop     <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_to       <= w_to_nxt;
            r_add      <= w_push;
            r_owner    <= owner_of(w_state_nxt);
            r_drop     <= w_mir_drop || w_fir_drop;
            r_drop_cnt <= sat_add8(r_drop_cnt, {1'b0, w_mir_drop} + {1'b0, w_fir_drop});
            if (w_push) begin
                r_dat <= w_own_head.dat;
            end
        end
    end

    assign bus.rxfifo_add_o = r_add;
    assign bus.rxfifo_dat_o = r_dat;
    assign bus.owner_o      = r_owner;
    assign bus.drop_o       = r_drop;
    assign bus.drop_cnt_o   = r_drop_cnt;

endmodule
